// File: rtl/wb_openram_arbiter_if.sv
// Wishbone slave bundle for the OpenRAM arbiter.
// Per-port signals are packed side by side, port p in slice p.
interface wb_openram_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_W = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]                  wbs_stb_i;
    logic [NUM_PORTS-1:0]                  wbs_cyc_i;
    logic [NUM_PORTS-1:0]                  wbs_we_i;
    logic [NUM_PORTS*SEL_W-1:0]            wbs_sel_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0]       wbs_dat_i;
    logic [NUM_PORTS*(ADDR_WIDTH+2)-1:0]   wbs_adr_i;
    logic [NUM_PORTS-1:0]                  wbs_ack_o;
    logic [NUM_PORTS*DATA_WIDTH-1:0]       wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i,
        output wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
        input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_openram_arbiter.sv
// Round-robin Wishbone front-end sharing one OpenRAM RW port.
// One access in flight; read wait states replace clock stretching.
module wb_openram_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int READ_WAIT  = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    wb_openram_arbiter_if.slave     bus,
    output logic                    ram_clk0,
    output logic                    ram_csb0,
    output logic                    ram_web0,
    output logic [DATA_WIDTH/8-1:0] ram_wmask0,
    output logic [ADDR_WIDTH-1:0]   ram_addr0,
    output logic [DATA_WIDTH-1:0]   ram_din0,
    input  logic [DATA_WIDTH-1:0]   ram_dout0
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int AW2   = ADDR_WIDTH + 2;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW    = $clog2(READ_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    state_t                state;
    state_t                state_next;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_next;
    logic [PW-1:0]         grant;
    logic [PW-1:0]         pick;
    logic [PW-1:0]         idx;
    logic                  found;
    logic                  live;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] rdata;
    logic [NUM_PORTS-1:0]  req;
    logic                  unused_adr;

    assign req        = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign live       = bus.wbs_cyc_i[grant];
    assign ram_clk0   = wb_clk_i;
    assign unused_adr = ^bus.wbs_adr_i;

    // Search ptr, ptr+1, ... with wrap; first requester wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (int'(ptr) + i >= NUM_PORTS)
                idx = PW'(int'(ptr) + i - NUM_PORTS);
            else
                idx = PW'(int'(ptr) + i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign ptr_next = (int'(pick) == NUM_PORTS - 1) ? '0 : pick + 1'b1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ram_web0 still holds the access type while in ACCESS.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (found)
                    state_next = ACCESS;
            end
            ACCESS: begin
                if (!live)
                    state_next = IDLE;
                else if (ram_web0)
                    state_next = WAIT;
                else
                    state_next = ACK;
            end
            WAIT: begin
                if (!live)
                    state_next = IDLE;
                else if (cnt == CW'(1))
                    state_next = ACK;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr        <= '0;
            grant      <= '0;
            cnt        <= '0;
            rdata      <= '0;
            ram_csb0   <= 1'b1;
            ram_web0   <= 1'b1;
            ram_wmask0 <= '0;
            ram_addr0  <= '0;
            ram_din0   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= pick;
                        ptr        <= ptr_next;
                        ram_addr0  <= bus.wbs_adr_i[int'(pick)*AW2 + 2 +: ADDR_WIDTH];
                        ram_din0   <= bus.wbs_dat_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                        ram_csb0   <= 1'b0;
                        ram_web0   <= ~bus.wbs_we_i[pick];
                        ram_wmask0 <= bus.wbs_we_i[pick] ?
                                      bus.wbs_sel_i[int'(pick)*SEL_W +: SEL_W] : '0;
                    end
                end
                ACCESS: begin
                    ram_csb0   <= 1'b1;
                    ram_web0   <= 1'b1;
                    ram_wmask0 <= '0;
                    if (ram_web0)
                        cnt <= CW'(READ_WAIT);
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (live && cnt == CW'(1))
                        rdata <= ram_dout0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.wbs_ack_o = '0;
        if (state == ACK && live)
            bus.wbs_ack_o[grant] = 1'b1;
    end

    assign bus.wbs_dat_o = {NUM_PORTS{rdata}};
endmodule

// File: tb/tb_wb_openram_arbiter.sv
// Bench for wb_openram_arbiter: directed scenarios plus randomized
// two-port traffic checked against a word-array memory and rotating grant model.
module tb_wb_openram_arbiter;
    localparam int NP = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int RW = 1;

    logic          clk;
    logic          rst;
    logic          ram_clk0;
    logic          ram_csb0;
    logic          ram_web0;
    logic [3:0]    ram_wmask0;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] ram_din0;
    logic [DW-1:0] ram_dout0 = '0;

    logic [DW-1:0] ram     [256] = '{default: '0};
    logic [DW-1:0] ref_mem [256] = '{default: '0};

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_ptr = 0;

    wb_openram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_openram_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_WAIT(RW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .bus        (bus),
        .ram_clk0   (ram_clk0),
        .ram_csb0   (ram_csb0),
        .ram_web0   (ram_web0),
        .ram_wmask0 (ram_wmask0),
        .ram_addr0  (ram_addr0),
        .ram_din0   (ram_din0),
        .ram_dout0  (ram_dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural OpenRAM port: samples on the rising edge when selected.
    always @(posedge ram_clk0) begin
        if (!ram_csb0) begin
            if (!ram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask0[b])
                        ram[ram_addr0][8*b +: 8] <= ram_din0[8*b +: 8];
            end else begin
                ram_dout0 <= ram[ram_addr0];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic on, input logic we,
                         input logic [9:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
        bus.wbs_cyc_i[p]          = on;
        bus.wbs_stb_i[p]          = on;
        bus.wbs_we_i[p]           = we;
        bus.wbs_adr_i[p*10 +: 10] = adr;
        bus.wbs_sel_i[p*4 +: 4]   = sel;
        bus.wbs_dat_i[p*32 +: 32] = dat;
    endtask

    task automatic ref_write(input int word, input logic [3:0] sel,
                             input logic [31:0] dat);
        for (int b = 0; b < 4; b++)
            if (sel[b])
                ref_mem[word][8*b +: 8] = dat[8*b +: 8];
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        bus.wbs_cyc_i = '0;
        bus.wbs_stb_i = '0;
        bus.wbs_we_i  = '0;
        tick();
        tick();
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Single-port transaction; lat is cycles from request to ack, -1 on timeout.
    task automatic run_single(input int p, input logic we, input logic [9:0] adr,
                              input logic [3:0] sel, input logic [31:0] dat,
                              output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = '0;
        tick();
        drive(p, 1'b1, we, adr, sel, dat);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.wbs_ack_o[p]) begin
                lat = c;
                rd  = bus.wbs_dat_o[p*32 +: 32];
                break;
            end
        end
        tick();
        drive(p, 1'b0, 1'b0, '0, '0, '0);
        if (we)
            ref_write(int'(adr[9:2]), sel, dat);
        model_ptr = (p + 1) % NP;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wbs_cyc_i = '0;
        bus.wbs_stb_i = '0;
        bus.wbs_we_i  = '0;
        bus.wbs_sel_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_adr_i = '0;
        tick();
        tick();
        rst = 1'b0;
        model_ptr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total_cnt++;
            if (ram_csb0 !== 1'b1 || ram_web0 !== 1'b1 ||
                bus.wbs_ack_o !== '0 || bus.wbs_dat_o !== '0)
                $display("FAIL reset_idle cyc %0d: csb=%b web=%b ack=%b dat=%h, required 1 1 00 0",
                         c, ram_csb0, ram_web0, bus.wbs_ack_o, bus.wbs_dat_o);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_write();
        tick();
        drive(0, 1'b1, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        total_cnt++;
        if (bus.wbs_ack_o !== 2'b00)
            $display("FAIL write_t0_ack: got %b, required 00", bus.wbs_ack_o);
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0} !==
            {1'b0, 1'b0, 4'hF, 8'h04, 32'hDEADBEEF})
            $display("FAIL write_t1_ram: csb=%b web=%b wm=%h a=%h d=%h, required 0 0 f 04 deadbeef",
                     ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0);
        else
            pass_cnt++;
        total_cnt++;
        if (bus.wbs_ack_o !== 2'b00)
            $display("FAIL write_t1_ack: got %b, required 00", bus.wbs_ack_o);
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.wbs_ack_o !== 2'b01)
            $display("FAIL write_t2_ack: got %b, required 01", bus.wbs_ack_o);
        else
            pass_cnt++;
        tick();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        ref_write(4, 4'hF, 32'hDEADBEEF);
        model_ptr = 1;
        @(negedge clk);
        total_cnt++;
        if (bus.wbs_ack_o !== 2'b00 || ram_csb0 !== 1'b1)
            $display("FAIL write_t3_idle: ack=%b csb=%b, required 00 1", bus.wbs_ack_o, ram_csb0);
        else
            pass_cnt++;
    endtask

    task automatic test_read();
        int          lat;
        logic [31:0] rd;
        run_single(1, 1'b0, 10'h010, 4'hF, '0, lat, rd);
        total_cnt++;
        if (lat !== 3)
            $display("FAIL read_latency: got %0d, required 3", lat);
        else
            pass_cnt++;
        total_cnt++;
        if (rd !== 32'hDEADBEEF)
            $display("FAIL read_data: got %h, required deadbeef", rd);
        else
            pass_cnt++;
    endtask

    task automatic test_byte_write();
        int          lat;
        logic [31:0] rd;
        run_single(0, 1'b1, 10'h010, 4'b0010, 32'h0000AA00, lat, rd);
        total_cnt++;
        if (lat !== 2)
            $display("FAIL byte_write_latency: got %0d, required 2", lat);
        else
            pass_cnt++;
        run_single(0, 1'b0, 10'h010, 4'hF, '0, lat, rd);
        total_cnt++;
        if (rd !== 32'hDEADAAEF)
            $display("FAIL byte_write_data: got %h, required deadaaef", rd);
        else
            pass_cnt++;
        run_single(1, 1'b1, 10'h020, 4'b0000, 32'h12345678, lat, rd);
        total_cnt++;
        if (lat !== 2)
            $display("FAIL sel0_write_latency: got %0d, required 2", lat);
        else
            pass_cnt++;
        run_single(1, 1'b0, 10'h020, 4'hF, '0, lat, rd);
        total_cnt++;
        if (rd !== ref_mem[8])
            $display("FAIL sel0_write_data: got %h, required %h", rd, ref_mem[8]);
        else
            pass_cnt++;
    endtask

    task automatic test_alternate();
        int acks;
        int last_c;
        int exp_p;
        int got_p;
        acks   = 0;
        last_c = -1;
        tick();
        drive(0, 1'b1, 1'b0, 10'h010, 4'hF, '0);
        drive(1, 1'b1, 1'b0, 10'h020, 4'hF, '0);
        for (int c = 0; c < 60 && acks < 6; c++) begin
            @(negedge clk);
            if (bus.wbs_ack_o !== 2'b00) begin
                exp_p = model_ptr;
                got_p = bus.wbs_ack_o[1] ? 1 : 0;
                total_cnt++;
                if (bus.wbs_ack_o !== (2'b01 << exp_p))
                    $display("FAIL alternate_grant %0d: ack=%b, required port %0d",
                             acks, bus.wbs_ack_o, exp_p);
                else
                    pass_cnt++;
                total_cnt++;
                if (bus.wbs_dat_o[got_p*32 +: 32] !== ref_mem[got_p == 0 ? 4 : 8])
                    $display("FAIL alternate_data %0d: got %h, required %h", acks,
                             bus.wbs_dat_o[got_p*32 +: 32], ref_mem[got_p == 0 ? 4 : 8]);
                else
                    pass_cnt++;
                if (last_c >= 0) begin
                    total_cnt++;
                    if (c - last_c !== 4)
                        $display("FAIL alternate_spacing %0d: got %0d cycles, required 4",
                                 acks, c - last_c);
                    else
                        pass_cnt++;
                end
                last_c    = c;
                model_ptr = (exp_p + 1) % NP;
                acks++;
            end
        end
        total_cnt++;
        if (acks !== 6)
            $display("FAIL alternate_timeout: got %0d acks, required 6", acks);
        else
            pass_cnt++;
        tick();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_abort();
        int lat;
        do_reset();
        tick();
        drive(0, 1'b1, 1'b0, 10'h010, 4'hF, '0);
        drive(1, 1'b1, 1'b0, 10'h020, 4'hF, '0);
        tick();
        tick();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        total_cnt++;
        if (bus.wbs_ack_o !== 2'b00)
            $display("FAIL abort_wait_ack: got %b, required 00", bus.wbs_ack_o);
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.wbs_ack_o !== 2'b00 || ram_csb0 !== 1'b1 || bus.wbs_dat_o !== '0)
            $display("FAIL abort_idle: ack=%b csb=%b dat=%h, required 00 1 0",
                     bus.wbs_ack_o, ram_csb0, bus.wbs_dat_o);
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ram_csb0 !== 1'b0 || ram_addr0 !== 8'h08)
            $display("FAIL abort_regrant: csb=%b addr=%h, required 0 08", ram_csb0, ram_addr0);
        else
            pass_cnt++;
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            if (bus.wbs_ack_o[1]) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (lat !== 2 || bus.wbs_dat_o[63:32] !== ref_mem[8])
            $display("FAIL abort_port1: lat=%0d dat=%h, required 2 %h",
                     lat, bus.wbs_dat_o[63:32], ref_mem[8]);
        else
            pass_cnt++;
        tick();
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        model_ptr = 0;
    endtask

    task automatic test_reset_in_wait();
        logic [1:0] got;
        tick();
        drive(0, 1'b1, 1'b0, 10'h010, 4'hF, '0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        total_cnt++;
        if (ram_csb0 !== 1'b1 || ram_web0 !== 1'b1 || bus.wbs_ack_o !== 2'b00)
            $display("FAIL rst_wait: csb=%b web=%b ack=%b, required 1 1 00",
                     ram_csb0, ram_web0, bus.wbs_ack_o);
        else
            pass_cnt++;
        tick();
        rst = 1'b0;
        model_ptr = 0;
        drive(0, 1'b1, 1'b0, 10'h014, 4'hF, '0);
        drive(1, 1'b1, 1'b0, 10'h024, 4'hF, '0);
        @(negedge clk);
        tick();
        @(negedge clk);
        total_cnt++;
        if (ram_addr0 !== 8'h05 || ram_csb0 !== 1'b0)
            $display("FAIL rst_ptr: addr=%h csb=%b, required 05 0", ram_addr0, ram_csb0);
        else
            pass_cnt++;
        got = '0;
        for (int c = 0; c < 30 && got !== 2'b11; c++) begin
            @(negedge clk);
            got = got | bus.wbs_ack_o;
            tick();
            if (got[0]) drive(0, 1'b0, 1'b0, '0, '0, '0);
            if (got[1]) drive(1, 1'b0, 1'b0, '0, '0, '0);
        end
        total_cnt++;
        if (got !== 2'b11)
            $display("FAIL rst_recover: acks seen %b, required 11", got);
        else
            pass_cnt++;
        model_ptr = 0;
    endtask

    task automatic test_random();
        logic        t_we  [NP];
        logic [9:0]  t_adr [NP];
        logic [3:0]  t_sel [NP];
        logic [31:0] t_dat [NP];
        logic [1:0]  pending;
        logic [1:0]  acked;
        int          exp_p;
        int          word;
        do_reset();
        for (int r = 0; r < 30; r++) begin
            pending = 2'($urandom_range(1, 3));
            tick();
            for (int p = 0; p < NP; p++) begin
                t_we[p]  = 1'($urandom % 2);
                t_adr[p] = {8'($urandom_range(0, 7)), 2'($urandom)};
                t_sel[p] = 4'($urandom);
                t_dat[p] = $urandom;
                if (pending[p])
                    drive(p, 1'b1, t_we[p], t_adr[p], t_sel[p], t_dat[p]);
            end
            for (int c = 0; c < 40 && pending !== 2'b00; c++) begin
                @(negedge clk);
                acked = bus.wbs_ack_o;
                if (acked !== 2'b00) begin
                    exp_p = pending[model_ptr] ? model_ptr : (model_ptr + 1) % NP;
                    word  = int'(t_adr[exp_p][9:2]);
                    total_cnt++;
                    if (acked !== (2'b01 << exp_p))
                        $display("FAIL rand_grant r%0d: ack=%b, required port %0d",
                                 r, acked, exp_p);
                    else
                        pass_cnt++;
                    if (!t_we[exp_p]) begin
                        total_cnt++;
                        if (bus.wbs_dat_o[exp_p*32 +: 32] !== ref_mem[word])
                            $display("FAIL rand_read r%0d: got %h, required %h", r,
                                     bus.wbs_dat_o[exp_p*32 +: 32], ref_mem[word]);
                        else
                            pass_cnt++;
                    end else begin
                        ref_write(word, t_sel[exp_p], t_dat[exp_p]);
                    end
                    model_ptr = (exp_p + 1) % NP;
                    pending   = pending & ~acked;
                end
                tick();
                for (int p = 0; p < NP; p++)
                    if (acked[p])
                        drive(p, 1'b0, 1'b0, '0, '0, '0);
            end
            if (pending !== 2'b00) begin
                total_cnt++;
                $display("FAIL rand_timeout r%0d: pending %b, required 00", r, pending);
                drive(0, 1'b0, 1'b0, '0, '0, '0);
                drive(1, 1'b0, 1'b0, '0, '0, '0);
                do_reset();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_alternate();
        test_abort();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
